// File: rtl/serial_word_transmitter.sv
// Serial word transmitter: accepts a parallel word over valid/ready, shifts it out
// LSB-first on x (one bit per clock), then appends a parity bit. frame marks every
// data/parity cycle, parity_slot marks the parity cycle and done pulses on the
// cycle after the parity bit. Frames may run back-to-back with no idle gap.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no frame active, x held at IDLE_LEVEL, ready for a word
//   ST_SHIFT  | data bits on x; cnt_q is the index (1..WIDTH) of the bit on x
//   ST_PARITY | parity bit on x; a new word may be accepted for a gapless start
module serial_word_transmitter #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          PARITY_ODD = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x,
    output logic             frame,
    output logic             parity_slot,
    output logic             done
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             par_q;
    logic             x_q;
    logic             frame_q;
    logic             parity_slot_q;
    logic             done_q;

    logic             accept;
    logic [WIDTH-1:0] shreg_d;
    logic             par_d;

    // Ready only while no data bit is pending; gated by reset_n so it drops immediately.
    assign data_ready = reset_n & ((state_q == ST_IDLE) | (state_q == ST_PARITY));
    assign accept     = data_valid & data_ready;

    // Load values for an accepted word: bit 0 goes straight to x, the rest is queued.
    always_comb begin
        shreg_d = data_in >> 1;
        par_d   = PARITY_ODD ^ (^data_in);
    end

    // Frame sequencer with registered serial output and strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            par_q         <= 1'b0;
            x_q           <= IDLE_LEVEL;
            frame_q       <= 1'b0;
            parity_slot_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shreg_q       <= shreg_d;
                        par_q         <= par_d;
                        x_q           <= data_in[0];
                        frame_q       <= 1'b1;
                        parity_slot_q <= 1'b0;
                        cnt_q         <= CNT_ONE;
                        state_q       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
                        x_q           <= par_q;
                        parity_slot_q <= 1'b1;
                        state_q       <= ST_PARITY;
                    end else begin
                        x_q     <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                ST_PARITY: begin
                    done_q <= 1'b1;
                    if (accept) begin
                        shreg_q       <= shreg_d;
                        par_q         <= par_d;
                        x_q           <= data_in[0];
                        frame_q       <= 1'b1;
                        parity_slot_q <= 1'b0;
                        cnt_q         <= CNT_ONE;
                        state_q       <= ST_SHIFT;
                    end else begin
                        x_q           <= IDLE_LEVEL;
                        frame_q       <= 1'b0;
                        parity_slot_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    x_q           <= IDLE_LEVEL;
                    frame_q       <= 1'b0;
                    parity_slot_q <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign x           = x_q;
    assign frame       = frame_q;
    assign parity_slot = parity_slot_q;
    assign done        = done_q;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Bench for serial_word_transmitter: an even-parity/idle-low instance and an
// odd-parity/idle-high instance share the same stimulus. The driver pushes the
// expected frame bits on each acceptance; a negedge monitor pops and compares.
module tb_serial_word_transmitter;

    logic       clock;
    logic       reset_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready, x, frame, parity_slot, done;
    logic       ready_o, x_o, frame_o, ps_o, done_o;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    logic pend_done = 1'b0;
    logic run_e = 1'b0;
    logic run_o = 1'b0;

    serial_word_transmitter #(.WIDTH(8), .PARITY_ODD(1'b0), .IDLE_LEVEL(1'b0)) u_even (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .x(x), .frame(frame), .parity_slot(parity_slot), .done(done)
    );

    serial_word_transmitter #(.WIDTH(8), .PARITY_ODD(1'b1), .IDLE_LEVEL(1'b1)) u_odd (
        .clock(clock), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_o), .x(x_o), .frame(frame_o), .parity_slot(ps_o), .done(done_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one comparison set per cycle, sampled on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            exp_q.delete();
            pend_done = 1'b0;
            run_e = 1'b0;
            run_o = 1'b0;
            chk("rst_frame", frame, 1'b0);
            chk("rst_x", x, 1'b0);
            chk("rst_ps", parity_slot, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_ready", data_ready, 1'b0);
            chk("rst_x_odd", x_o, 1'b1);
            chk("rst_frame_odd", frame_o, 1'b0);
        end else begin
            chk("done", done, pend_done);
            chk("done_odd", done_o, pend_done);
            pend_done = 1'b0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("frame", frame, 1'b1);
                chk("x", x, e.b);
                chk("parity_slot", parity_slot, e.last);
                chk("ready", data_ready, e.last);
                chk("frame_odd", frame_o, 1'b1);
                chk("x_odd", x_o, e.b ^ e.last);
                chk("parity_slot_odd", ps_o, e.last);
                chk("ready_odd", ready_o, e.last);
                run_e = run_e ^ x;
                run_o = run_o ^ x_o;
                if (e.last) begin
                    chk("run_parity_even", run_e, 1'b0);
                    chk("run_parity_odd", run_o, 1'b1);
                    run_e = 1'b0;
                    run_o = 1'b0;
                    pend_done = 1'b1;
                end
            end else begin
                chk("idle_frame", frame, 1'b0);
                chk("idle_x", x, 1'b0);
                chk("idle_ps", parity_slot, 1'b0);
                chk("idle_ready", data_ready, 1'b1);
                chk("idle_frame_odd", frame_o, 1'b0);
                chk("idle_x_odd", x_o, 1'b1);
                chk("idle_ready_odd", ready_o, 1'b1);
            end
        end
    end

    // f = {parity bit, data bits}; transmitted LSB first, parity last.
    task automatic push_frame(input logic [8:0] f);
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            e.b    = f[i];
            e.last = (i == 8);
            exp_q.push_back(e);
        end
    endtask

    // Present a word and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [7:0] w, input logic [8:0] f);
        int n;
        n = 0;
        @(negedge clock);
        #2;
        data_in    = w;
        data_valid = 1'b1;
        while (!data_ready && n < 40) begin
            @(negedge clock);
            #2;
            n++;
        end
        if (!data_ready) begin
            chk("accept_timeout", data_ready, 1'b1);
            data_valid = 1'b0;
        end else begin
            push_frame(f);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic gap(input int n);
        data_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        reset_n    = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        repeat (3) @(negedge clock);
        #2;
        reset_n = 1'b1;
        gap(2);

        // single frames: A5 (even parity 0), 07 (parity 1), 00 (parity 0 even / 1 odd)
        send(8'hA5, 9'h0A5);
        gap(3);
        send(8'h07, 9'h107);
        gap(2);
        send(8'h00, 9'h000);
        gap(2);

        // back-to-back with valid held: 01 (parity 1) then FF (parity 0)
        send(8'h01, 9'h101);
        send(8'hFF, 9'h0FF);
        gap(12);

        // reset mid-frame: aborted frame, no done, then a full frame
        send(8'h3C, 9'h03C);
        repeat (4) @(negedge clock);
        #2;
        reset_n    = 1'b0;
        data_valid = 1'b0;
        #1;
        chk("async_rst_x", x, 1'b0);
        chk("async_rst_frame", frame, 1'b0);
        chk("async_rst_ready", data_ready, 1'b0);
        chk("async_rst_x_odd", x_o, 1'b1);
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        gap(2);
        send(8'hC3, 9'h0C3);
        gap(12);

        // input activity during SHIFT must not disturb the frame in flight
        send(8'h96, 9'h096);
        repeat (6) begin
            @(negedge clock);
            #2;
            data_in    = 8'($urandom);
            data_valid = 1'($urandom);
        end
        @(negedge clock);
        #2;
        data_valid = 1'b0;
        gap(6);

        // random words, random back-to-back / idle gaps
        for (int i = 0; i < 1000; i++) begin
            w = 8'($urandom);
            send(w, {^w, w});
            if ($urandom_range(0, 2) != 0) gap($urandom_range(0, 3));
        end
        gap(15);
        chk("queue_drained", exp_q.size() == 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
